// File: rtl/lsu_mem_port.sv
// ============================================================================
// Module  : lsu_mem_port
// Brief   : Single-beat load/store unit that turns a decoded RISC-V load or
//           store into one valid/ready memory access.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_mem_port #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Counter value on the last cycle mem_valid may stay high without ready.
    localparam logic [CNT_W-1:0] c_TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic             c_TO_EN   = (TIMEOUT != 0);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_addr;
    logic [2:0]         r_funct3;
    logic               r_is_load;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wmask;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_load_data;

    logic               w_accept;
    logic               w_illegal;
    logic               w_hs;
    logic               w_timeout;
    logic [31:0]        w_wdata;
    logic [3:0]         w_wmask;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic               w_sext;
    logic [31:0]        w_load_ext;

    assign w_accept = (r_state == S_IDLE) && start && (is_load ^ is_store);

    assign w_illegal = (is_load && is_store)
                    || (funct3[1:0] == 2'b11)
                    || (is_store && funct3[2])
                    || ((funct3[1:0] == 2'b01) && addr[0])
                    || ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    assign w_hs      = (r_state == S_REQ) && mem_ready;
    assign w_timeout = c_TO_EN && (r_state == S_REQ) && !mem_ready && (r_cnt == c_TO_LAST);

    // Store lanes are formed at accept time so the request is stable in REQ.
    always_comb begin
        w_wdata = store_data;
        w_wmask = 4'b0000;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    w_wdata = {4{store_data[7:0]}};
                    w_wmask = 4'b0001 << addr[1:0];
                end
                2'b01: begin
                    w_wdata = {2{store_data[15:0]}};
                    w_wmask = addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    w_wdata = store_data;
                    w_wmask = 4'b1111;
                end
            endcase
        end
    end

    assign w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = mem_rdata[{r_addr[1], 4'b0000} +: 16];
    assign w_sext = ~r_funct3[2];

    always_comb begin
        w_load_ext = mem_rdata;
        case (r_funct3[1:0])
            2'b00:   w_load_ext = {{24{w_sext & w_byte[7]}}, w_byte};
            2'b01:   w_load_ext = {{16{w_sext & w_half[15]}}, w_half};
            default: w_load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_illegal ? S_FIN : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ready || w_timeout) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_funct3    <= '0;
            r_is_load   <= 1'b0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_load_data <= '0;
        end else begin
            if (w_accept) begin
                r_addr    <= addr;
                r_funct3  <= funct3;
                r_is_load <= is_load;
                r_wdata   <= w_wdata;
                r_wmask   <= w_wmask;
                r_err     <= w_illegal;
                r_cnt     <= '0;
            end else if ((r_state == S_REQ) && !mem_ready) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end
            if (w_hs && r_is_load) begin
                r_load_data <= w_load_ext;
            end
        end
    end

    assign busy      = (r_state == S_REQ);
    assign mem_valid = (r_state == S_REQ);
    assign done      = (r_state == S_FIN);
    assign err       = (r_state == S_FIN) && r_err;
    assign mem_we    = (r_state == S_REQ) && !r_is_load;
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_wdata = r_wdata;
    assign mem_wmask = r_wmask;
    assign load_data = r_load_data;

endmodule

`default_nettype wire
